// File: rtl/color_state_sequencer.sv
// Colour-state sequencer: debounced next/prev keys and an optional auto-cycle timer
// step a wrapping 4-bit colour state, with registered step/wrap pulses.
module color_state_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_PERIOD     = 50000000,
    parameter int NUM_STATES      = 16
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic       iKEY_NEXT_n,
    input  logic       iKEY_PREV_n,
    input  logic       iAUTO,
    output logic [3:0] oSTATE,
    output logic       oSTEP,
    output logic       oWRAP
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int              AT_W    = $clog2(AUTO_PERIOD);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AT_W-1:0] AT_LAST = AT_W'(AUTO_PERIOD - 1);
    localparam logic [3:0]      ST_LAST = 4'(NUM_STATES - 1);

    // Key index 0 is "next", index 1 is "prev".
    logic [1:0]      key_p0, key_p1;
    logic [1:0]      key_deb, key_deb_d;
    logic [DB_W-1:0] db_cnt [2];
    logic            auto_p0, auto_p1;
    logic [AT_W-1:0] auto_cnt;

    logic [1:0]      deb_flip, key_press;
    logic            auto_tick, next_req, prev_req;
    logic [3:0]      state_nxt;
    logic            step_nxt, wrap_nxt;
    logic [AT_W-1:0] auto_cnt_nxt;

    always_comb begin
        deb_flip  = '0;
        key_press = '0;
        for (int i = 0; i < 2; i++) begin
            deb_flip[i]  = (key_p1[i] != key_deb[i]) && (db_cnt[i] == DB_LAST);
            key_press[i] = key_deb_d[i] & ~key_deb[i];
        end
    end

    assign auto_tick = auto_p1 && (auto_cnt == AT_LAST);
    assign next_req  = key_press[0] | auto_tick;
    assign prev_req  = key_press[1];

    // Opposing requests cancel the step but still restart the auto timer.
    always_comb begin
        state_nxt    = oSTATE;
        step_nxt     = 1'b0;
        wrap_nxt     = 1'b0;
        auto_cnt_nxt = auto_cnt + AT_W'(1);
        if (!auto_p1 || next_req || prev_req) begin
            auto_cnt_nxt = '0;
        end
        if (next_req && !prev_req) begin
            step_nxt = 1'b1;
            if (oSTATE == ST_LAST) begin
                state_nxt = 4'd0;
                wrap_nxt  = 1'b1;
            end else begin
                state_nxt = oSTATE + 4'd1;
            end
        end else if (prev_req && !next_req) begin
            step_nxt = 1'b1;
            if (oSTATE == 4'd0) begin
                state_nxt = ST_LAST;
                wrap_nxt  = 1'b1;
            end else begin
                state_nxt = oSTATE - 4'd1;
            end
        end
    end

    // Stage boundary: input synchronizers and debounce.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            key_p0    <= 2'b11;
            key_p1    <= 2'b11;
            key_deb   <= 2'b11;
            key_deb_d <= 2'b11;
            auto_p0   <= 1'b0;
            auto_p1   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            key_p0    <= {iKEY_PREV_n, iKEY_NEXT_n};
            key_p1    <= key_p0;
            key_deb_d <= key_deb;
            auto_p0   <= iAUTO;
            auto_p1   <= auto_p0;
            for (int i = 0; i < 2; i++) begin
                if (key_p1[i] == key_deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (deb_flip[i]) begin
                    key_deb[i] <= key_p1[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Stage boundary: auto timer and registered colour state / pulses.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            auto_cnt <= '0;
            oSTATE   <= 4'd0;
            oSTEP    <= 1'b0;
            oWRAP    <= 1'b0;
        end else begin
            auto_cnt <= auto_cnt_nxt;
            oSTATE   <= state_nxt;
            oSTEP    <= step_nxt;
            oWRAP    <= wrap_nxt;
        end
    end

endmodule
